// File: rtl/demux4_buf.sv
// demux4_buf: registered 1-to-4 demultiplexer with a one-entry holding
// register and valid/ready handshake per output lane. A stalled consumer
// only blocks words addressed to its own lane; other lanes keep flowing.
module demux4_buf #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic               busy
);

  logic [WIDTH-1:0] r_laneData [4];
  logic [3:0]       r_laneValid;

  logic             w_laneFree;
  logic             w_accept;
  logic [3:0]       w_acceptVec;
  logic [3:0]       w_drainVec;

  // The addressed lane can take a word if it is empty or is being drained
  // on this same edge; the state of the other lanes never matters here.
  always_comb begin
    w_laneFree  = ~r_laneValid[in_sel] | out_ready[in_sel];
    in_ready    = ~reset & w_laneFree;
    w_accept    = in_valid & in_ready;
    w_acceptVec = w_accept ? (4'b0001 << in_sel) : 4'b0000;
    w_drainVec  = r_laneValid & out_ready;
  end

  // Per-lane holding registers: a write wins over a drain on the same
  // edge so a draining lane can be refilled without a bubble; a lane
  // that is neither written nor drained holds its word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_laneValid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_laneData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_acceptVec[i]) begin
          r_laneData[i]  <= in_data;
          r_laneValid[i] <= 1'b1;
        end else if (w_drainVec[i]) begin
          r_laneValid[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten the lane registers onto the output bus and summarise occupancy.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_data[i*WIDTH +: WIDTH] = r_laneData[i];
    end
    out_valid = r_laneValid;
    busy      = |r_laneValid;
  end

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: directed stimulus for demux4_buf with a per-lane queue
// model of buffered words, a per-cycle compare process, and literal
// expectations at the interesting points of each scenario.
module tb_demux4_buf;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic               busy;

  int checkCount;
  int errorCount;
  bit modelLive;

  // Each lane is a queue of words the consumer has not yet taken.
  logic [WIDTH-1:0] laneQ [4][$];
  // Words the DUT actually handed to consumer 0, in order.
  logic [WIDTH-1:0] lane0Log [$];

  demux4_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic setInputs(input logic rst, input logic vld, input logic [1:0] sel,
                           input logic [WIDTH-1:0] data, input logic [3:0] rdy);
    reset     = rst;
    in_valid  = vld;
    in_sel    = sel;
    in_data   = data;
    out_ready = rdy;
  endtask

  // Drive one cycle's inputs and return just after the following edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [1:0] sel,
                               input logic [WIDTH-1:0] data, input logic [3:0] rdy);
    setInputs(rst, vld, sel, data, rdy);
    @(posedge clk);
    #1;
  endtask

  function automatic logic modelReady();
    if (reset) return 1'b0;
    return (laneQ[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  function automatic logic [3:0] modelValid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (laneQ[i].size() != 0);
    return v;
  endfunction

  // Model update: consumers take the head of their lane, then an accepted
  // word joins the tail of its lane; reset throws every queued word away.
  always @(posedge clk) begin
    logic acc;
    acc = in_valid && modelReady();
    if (!reset && out_valid[0] && out_ready[0]) lane0Log.push_back(out_data[WIDTH-1:0]);
    if (reset) begin
      for (int i = 0; i < 4; i++) laneQ[i].delete();
      modelLive = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (laneQ[i].size() != 0 && out_ready[i]) void'(laneQ[i].pop_front());
      if (acc) laneQ[in_sel].push_back(in_data);
      for (int i = 0; i < 4; i++)
        if (laneQ[i].size() > 1) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL model_overflow lane=%0d depth=%0d expected<=1", i,
                   laneQ[i].size());
        end
    end
  end

  // Compare the DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (modelLive) begin
      logic [3:0] v;
      v = modelValid();
      checkOutput("in_ready", in_ready, modelReady());
      checkOutput("out_valid", out_valid, v);
      checkOutput("busy", busy, |v);
      for (int i = 0; i < 4; i++)
        if (v[i]) checkOutput($sformatf("lane%0d_data", i),
                              out_data[i*WIDTH +: WIDTH], laneQ[i][0]);
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelLive  = 1'b0;
    setInputs(1'b1, 1'b1, 2'd0, 8'hAA, 4'b0000);

    // Reset held for two cycles with a word offered.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hAA, 4'b0000);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hAA, 4'b0000);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_out_valid", out_valid, 4'b0000);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_busy", busy, 1'b0);

    // Single route to lane 2, held, then drained.
    applyStimulus(1'b0, 1'b1, 2'd2, 8'h5C, 4'b0000);
    checkOutput("route_valid", out_valid, 4'b0100);
    checkOutput("route_data", out_data[23:16], 8'h5C);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    checkOutput("hold_valid", out_valid, 4'b0100);
    checkOutput("hold_data", out_data[23:16], 8'h5C);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0100);
    checkOutput("drain_valid", out_valid, 4'b0000);

    // Backpressure on lane 1 must not block lane 3.
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h77, 4'b0000);
    setInputs(1'b0, 1'b1, 2'd1, 8'h88, 4'b0000);
    #1 checkOutput("bp_blocked_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("bp_lane1_kept", out_data[15:8], 8'h77);
    setInputs(1'b0, 1'b1, 2'd3, 8'h88, 4'b0000);
    #1 checkOutput("bp_other_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    checkOutput("bp_lane3_data", out_data[31:24], 8'h88);
    checkOutput("bp_lane1_data", out_data[15:8], 8'h77);
    checkOutput("bp_valid", out_valid, 4'b1010);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b1010);

    // Pass-through on lane 0 without bubbles.
    lane0Log.delete();
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h11, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h22, 4'b0001);
    checkOutput("pt_valid", out_valid, 4'b0001);
    checkOutput("pt_data22", out_data[7:0], 8'h22);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h33, 4'b0001);
    checkOutput("pt_data33", out_data[7:0], 8'h33);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001);
    checkOutput("pt_empty", out_valid, 4'b0000);
    checkOutput("pt_log_len", lane0Log.size(), 3);
    if (lane0Log.size() == 3) begin
      checkOutput("pt_log0", lane0Log[0], 8'h11);
      checkOutput("pt_log1", lane0Log[1], 8'h22);
      checkOutput("pt_log2", lane0Log[2], 8'h33);
    end

    // Mixed traffic: fill all four lanes, drain 1 and 3 while writing 3.
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b1, 2'(k), 8'(k + 1), 4'b0000);
    checkOutput("mix_full", out_valid, 4'b1111);
    applyStimulus(1'b0, 1'b1, 2'd3, 8'hF0, 4'b1010);
    checkOutput("mix_valid", out_valid, 4'b1101);
    checkOutput("mix_lane3", out_data[31:24], 8'hF0);
    checkOutput("mix_lane0", out_data[7:0], 8'h01);
    checkOutput("mix_lane2", out_data[23:16], 8'h03);
    checkOutput("mix_busy", busy, 1'b1);

    // Mid-operation reset with all lanes full, then normal operation.
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h55, 4'b0000);
    checkOutput("mr_full", out_valid, 4'b1111);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h99, 4'b1111);
    checkOutput("mr_valid", out_valid, 4'b0000);
    checkOutput("mr_data", out_data, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h66, 4'b0000);
    checkOutput("mr_new_valid", out_valid, 4'b0001);
    checkOutput("mr_new_data", out_data[7:0], 8'h66);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
